// File: rtl/dec_exe_pipe_reg_pkg.sv
// Shared types and constants for the decode-to-execute stage register.
package dec_exe_pkg;

   localparam int unsigned REG_W     = 5;
   localparam int unsigned ALUCTRL_W = 4;

   // Result mux select encoding
   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_e;

   // Decoded control bundle carried through the stage as one vector
   typedef struct packed {
      logic                 RegWrite;
      result_src_e          ResultSrc;
      logic                 MemWrite;
      logic                 Jump;
      logic                 JumpReg;
      logic                 Branch;
      logic [ALUCTRL_W-1:0] ALUControl;
      logic                 ALUSrc;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/dec_exe_pipe_reg_if.sv
// Decode-side inputs, hazard controls and execute-side outputs of the D/E register.
interface dec_exe_pipe_reg_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned REG_W     = 5,
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned CNT_W     = 16
);

   // hazard controls
   logic                 StallE;
   logic                 FlushE;
   logic                 CntClr;

   // decode side
   logic                 ValidD;
   logic                 RegWriteD;
   logic                 MemWriteD;
   logic                 JumpD;
   logic                 JumpRegD;
   logic                 BranchD;
   logic                 ALUSrcD;
   logic [1:0]           ResultSrcD;
   logic [ALUCTRL_W-1:0] ALUControlD;
   logic [WIDTH-1:0]     RD1D;
   logic [WIDTH-1:0]     RD2D;
   logic [WIDTH-1:0]     PCD;
   logic [WIDTH-1:0]     ImmExtD;
   logic [WIDTH-1:0]     PCPlus4D;
   logic [REG_W-1:0]     Rs1D;
   logic [REG_W-1:0]     Rs2D;
   logic [REG_W-1:0]     RdD;

   // execute side
   logic                 ValidE;
   logic                 RegWriteE;
   logic                 MemWriteE;
   logic                 JumpE;
   logic                 JumpRegE;
   logic                 BranchE;
   logic                 ALUSrcE;
   logic [1:0]           ResultSrcE;
   logic [ALUCTRL_W-1:0] ALUControlE;
   logic [WIDTH-1:0]     RD1E;
   logic [WIDTH-1:0]     RD2E;
   logic [WIDTH-1:0]     PCE;
   logic [WIDTH-1:0]     ImmExtE;
   logic [WIDTH-1:0]     PCPlus4E;
   logic [REG_W-1:0]     Rs1E;
   logic [REG_W-1:0]     Rs2E;
   logic [REG_W-1:0]     RdE;

   // performance counters
   logic [CNT_W-1:0]     StallCount;
   logic [CNT_W-1:0]     FlushCount;

   // decode stage / hazard unit side
   modport master (
      output StallE, FlushE, CntClr,
      output ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD,
      output ResultSrcD, ALUControlD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
      output Rs1D, Rs2D, RdD,
      input  ValidE, RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE,
      input  ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
      input  Rs1E, Rs2E, RdE, StallCount, FlushCount
   );

   // pipeline register side
   modport slave (
      input  StallE, FlushE, CntClr,
      input  ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD,
      input  ResultSrcD, ALUControlD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
      input  Rs1D, Rs2D, RdD,
      output ValidE, RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE,
      output ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
      output Rs1E, Rs2E, RdE, StallCount, FlushCount
   );

endinterface

// File: rtl/dec_exe_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // count up to all-ones and stick there until cleared
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dec_exe_pipe_reg.sv
// Decode-to-execute pipeline register with stall, flush, valid and event counters.
module dec_exe_pipe_reg #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned REG_W     = 5,
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned CNT_W     = 16
) (
   input logic               CLK,
   input logic               RST,
   dec_exe_pipe_reg_if.slave bus
);

   import dec_exe_pkg::*;

   ctrl_t            ctrl_d;
   ctrl_t            ctrl_q;
   logic             valid_q;
   logic [WIDTH-1:0] rd1_q;
   logic [WIDTH-1:0] rd2_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] imm_q;
   logic [WIDTH-1:0] pc4_q;
   logic [REG_W-1:0] rs1_q;
   logic [REG_W-1:0] rs2_q;
   logic [REG_W-1:0] rd_q;
   logic             stall_inc;

   // pack the decoded control bits into one bundle
   always_comb begin
      ctrl_d            = CTRL_NOP;
      ctrl_d.RegWrite   = bus.RegWriteD;
      ctrl_d.ResultSrc  = result_src_e'(bus.ResultSrcD);
      ctrl_d.MemWrite   = bus.MemWriteD;
      ctrl_d.Jump       = bus.JumpD;
      ctrl_d.JumpReg    = bus.JumpRegD;
      ctrl_d.Branch     = bus.BranchD;
      ctrl_d.ALUControl = bus.ALUControlD;
      ctrl_d.ALUSrc     = bus.ALUSrcD;
   end

   // stage register: flush inserts a bubble, stall holds, otherwise load
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
         rd1_q   <= '0;
         rd2_q   <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else if (bus.FlushE) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
         rd1_q   <= '0;
         rd2_q   <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else if (!bus.StallE) begin
         valid_q <= bus.ValidD;
         ctrl_q  <= ctrl_d;
         rd1_q   <= bus.RD1D;
         rd2_q   <= bus.RD2D;
         pc_q    <= bus.PCD;
         imm_q   <= bus.ImmExtD;
         pc4_q   <= bus.PCPlus4D;
         rs1_q   <= bus.Rs1D;
         rs2_q   <= bus.Rs2D;
         rd_q    <= bus.RdD;
      end
   end

   // a stall only counts when it is not overridden by a flush
   assign stall_inc = bus.StallE & ~bus.FlushE;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (bus.CntClr),
      .inc   (stall_inc),
      .count (bus.StallCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (bus.CntClr),
      .inc   (bus.FlushE),
      .count (bus.FlushCount)
   );

   assign bus.ValidE      = valid_q;
   assign bus.RegWriteE   = ctrl_q.RegWrite;
   assign bus.ResultSrcE  = ctrl_q.ResultSrc;
   assign bus.MemWriteE   = ctrl_q.MemWrite;
   assign bus.JumpE       = ctrl_q.Jump;
   assign bus.JumpRegE    = ctrl_q.JumpReg;
   assign bus.BranchE     = ctrl_q.Branch;
   assign bus.ALUControlE = ctrl_q.ALUControl;
   assign bus.ALUSrcE     = ctrl_q.ALUSrc;
   assign bus.RD1E        = rd1_q;
   assign bus.RD2E        = rd2_q;
   assign bus.PCE         = pc_q;
   assign bus.ImmExtE     = imm_q;
   assign bus.PCPlus4E    = pc4_q;
   assign bus.Rs1E        = rs1_q;
   assign bus.Rs2E        = rs2_q;
   assign bus.RdE         = rd_q;

endmodule

// File: tb/tb_dec_exe_pipe_reg.sv
// Self-checking bench for dec_exe_pipe_reg: reference model plus directed literal checks.
module tb_dec_exe_pipe_reg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned ALUCTRL_W = 4;
   localparam int unsigned CNT_W     = 4;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;

   logic CLK;
   logic RST;

   dec_exe_pipe_reg_if #(
      .WIDTH(WIDTH), .REG_W(REG_W), .ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)
   ) bus ();

   dec_exe_pipe_reg #(
      .WIDTH(WIDTH), .REG_W(REG_W), .ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected E-side contents as a flat record
   typedef struct packed {
      logic        valid;
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic        j;
      logic        jr;
      logic        br;
      logic [3:0]  alu;
      logic        asrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } e_t;

   int checks = 0;
   int passes = 0;

   e_t m_e;
   int m_sc;
   int m_fc;

   function automatic e_t snap_d();
      e_t s;
      s.valid = bus.ValidD;     s.rw  = bus.RegWriteD;  s.rs  = bus.ResultSrcD;
      s.mw    = bus.MemWriteD;  s.j   = bus.JumpD;      s.jr  = bus.JumpRegD;
      s.br    = bus.BranchD;    s.alu = bus.ALUControlD; s.asrc = bus.ALUSrcD;
      s.rd1   = bus.RD1D;       s.rd2 = bus.RD2D;       s.pc  = bus.PCD;
      s.imm   = bus.ImmExtD;    s.pc4 = bus.PCPlus4D;
      s.rs1   = bus.Rs1D;       s.rs2 = bus.Rs2D;       s.rd  = bus.RdD;
      return s;
   endfunction

   function automatic e_t snap_e();
      e_t s;
      s.valid = bus.ValidE;     s.rw  = bus.RegWriteE;  s.rs  = bus.ResultSrcE;
      s.mw    = bus.MemWriteE;  s.j   = bus.JumpE;      s.jr  = bus.JumpRegE;
      s.br    = bus.BranchE;    s.alu = bus.ALUControlE; s.asrc = bus.ALUSrcE;
      s.rd1   = bus.RD1E;       s.rd2 = bus.RD2E;       s.pc  = bus.PCE;
      s.imm   = bus.ImmExtE;    s.pc4 = bus.PCPlus4E;
      s.rs1   = bus.Rs1E;       s.rs2 = bus.Rs2E;       s.rd  = bus.RdE;
      return s;
   endfunction

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference model: reset clears, flush bubbles, stall holds, otherwise capture D
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_e  = '0;
         m_sc = 0;
         m_fc = 0;
      end else begin
         if (bus.CntClr) begin
            m_sc = 0;
            m_fc = 0;
         end else begin
            if (bus.FlushE)                       m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
            else if (bus.StallE)                  m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
         end
         if (bus.FlushE)       m_e = '0;
         else if (!bus.StallE) m_e = snap_d();
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      check("stage", 256'(snap_e()), 256'(m_e));
      check("stall_cnt", 256'(bus.StallCount), 256'(m_sc));
      check("flush_cnt", 256'(bus.FlushCount), 256'(m_fc));
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_d(input logic valid, input logic rw, input logic [3:0] alu,
                          input logic [31:0] rd1, input logic [31:0] pc, input logic [4:0] rd);
      bus.ValidD      = valid;
      bus.RegWriteD   = rw;
      bus.ALUControlD = alu;
      bus.RD1D        = rd1;
      bus.RD2D        = rd1 ^ 32'h5A5A_5A5A;
      bus.PCD         = pc;
      bus.ImmExtD     = pc + 32'h100;
      bus.PCPlus4D    = pc + 32'd4;
      bus.Rs1D        = rd + 5'd1;
      bus.Rs2D        = rd + 5'd2;
      bus.RdD         = rd;
      bus.ResultSrcD  = rd[1:0];
      bus.MemWriteD   = rd[2];
      bus.JumpD       = rd[3];
      bus.JumpRegD    = rd[4];
      bus.BranchD     = alu[0];
      bus.ALUSrcD     = alu[1];
   endtask

   initial begin
      RST        = 1'b1;
      bus.StallE = 1'b0;
      bus.FlushE = 1'b0;
      bus.CntClr = 1'b0;
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      tick();
      tick();
      check("reset_valid", 256'(bus.ValidE), 256'(0));
      RST = 1'b0;

      // async reset with no clock edge
      drive_d(1'b1, 1'b1, 4'h3, 32'hDEADBEEF, 32'h20, 5'd3);
      tick();
      check("load_rd1", 256'(bus.RD1E), 256'(32'hDEADBEEF));
      #1 RST = 1'b1;
      #1;
      check("areset_rd1", 256'(bus.RD1E), 256'(0));
      check("areset_valid", 256'(bus.ValidE), 256'(0));
      check("areset_cnts", 256'({bus.StallCount, bus.FlushCount}), 256'(0));
      tick();
      RST = 1'b0;

      // full-width load
      drive_d(1'b1, 1'b1, 4'b1010, 32'h1111_2222, 32'h0000_0040, 5'd17);
      tick();
      check("alu_ctrl", 256'(bus.ALUControlE), 256'(4'b1010));
      check("regwrite", 256'(bus.RegWriteE), 256'(1));
      check("rd_idx", 256'(bus.RdE), 256'(17));
      check("pc", 256'(bus.PCE), 256'(32'h40));

      // stall hold for 3 edges while D changes
      bus.StallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_d(1'(i), 1'b0, 4'(i + 5), 32'hABC0_0000 + 32'(i), 32'h80 + 32'(4 * i), 5'(i + 2));
         tick();
      end
      bus.StallE = 1'b0;
      check("stall_alu", 256'(bus.ALUControlE), 256'(4'b1010));
      check("stall_rd", 256'(bus.RdE), 256'(17));
      check("stall_pc", 256'(bus.PCE), 256'(32'h40));
      check("stall_cnt3", 256'(bus.StallCount), 256'(3));
      check("flush_cnt0", 256'(bus.FlushCount), 256'(0));

      // stall and flush together give a bubble
      bus.StallE = 1'b1;
      bus.FlushE = 1'b1;
      tick();
      bus.StallE = 1'b0;
      bus.FlushE = 1'b0;
      check("bubble_all", 256'(snap_e()), 256'(0));
      check("bubble_fcnt", 256'(bus.FlushCount), 256'(1));
      check("bubble_scnt", 256'(bus.StallCount), 256'(3));

      // invalid slot still loads its fields
      drive_d(1'b0, 1'b1, 4'h6, 32'h7777_0000, 32'h44, 5'd9);
      tick();
      check("inv_valid", 256'(bus.ValidE), 256'(0));
      check("inv_regwrite", 256'(bus.RegWriteE), 256'(1));
      check("inv_fcnt", 256'(bus.FlushCount), 256'(1));

      // flush counter saturation, then clear beats increment
      bus.FlushE = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("sat_fcnt", 256'(bus.FlushCount), 256'(15));
      bus.CntClr = 1'b1;
      tick();
      bus.CntClr = 1'b0;
      bus.FlushE = 1'b0;
      check("clr_fcnt", 256'(bus.FlushCount), 256'(0));
      check("clr_scnt", 256'(bus.StallCount), 256'(0));

      // mixed traffic checked by the model each cycle
      for (int i = 0; i < 40; i++) begin
         drive_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 32'($urandom), 32'($urandom), 5'($urandom));
         bus.StallE = ($urandom_range(0, 3) == 0);
         bus.FlushE = ($urandom_range(0, 4) == 0);
         bus.CntClr = ($urandom_range(0, 15) == 0);
         tick();
      end
      bus.StallE = 1'b0;
      bus.FlushE = 1'b0;
      bus.CntClr = 1'b0;
      tick();
      @(negedge CLK);
      #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
